// File: rtl/mem3_reader.sv
// ============================================================================
// Module      : mem3_reader
// Description : Burst read sequencer for the mem3 synchronous memory; absorbs
//               the one-cycle read latency and streams words on valid/ready.
//               Optional feature macro: MEM3_READER_CHECKSUM_EN (XOR checksum).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem3_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef MEM3_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE  = LEN_WIDTH'(1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_length;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_popped;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_buf_count;

    logic                  w_pop;
    logic [2:0]            w_occupancy;
    logic                  w_issue;

    assign w_pop       = m_valid & m_ready;
    // Words that will sit in the buffer after this edge, before any new read.
    assign w_occupancy = {1'b0, r_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue     = (r_state == READ) && (r_issued != r_length) && (w_occupancy < 3'd2);

    assign busy             = (r_state != IDLE);
    assign done             = (r_state == DONE);
    assign mem_read_en      = w_issue;
    assign mem_read_address = r_addr;
    assign m_valid          = (r_buf_count != 2'd0);
    assign m_data           = r_buf[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_length    <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_inflight  <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_buf_count <= 2'd0;
        end else begin
            r_inflight <= w_issue;

            // mem_data_out is valid in the cycle after the read was sampled.
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= mem_data_out;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_popped <= r_popped + c_LEN_ONE;
            end
            case ({r_inflight, w_pop})
                2'b10:   r_buf_count <= r_buf_count + 2'd1;
                2'b01:   r_buf_count <= r_buf_count - 2'd1;
                default: r_buf_count <= r_buf_count;
            endcase

            if (w_issue) begin
                r_addr   <= r_addr + c_ADDR_ONE;
                r_issued <= r_issued + c_LEN_ONE;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            r_addr   <= base_addr;
                            r_length <= length;
                            r_issued <= '0;
                            r_popped <= '0;
                            r_state  <= READ;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (w_issue && (r_issued + c_LEN_ONE == r_length)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && (r_popped + c_LEN_ONE == r_length)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM3_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ m_data;
        end
    end

    assign checksum = r_checksum;
`else
    // No checksum state in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem3_reader.sv
// ============================================================================
// Module      : tb_mem3_reader
// Description : Self-checking bench for mem3_reader with a mem3 read model and
//               a queue scoreboard of expected stream words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem3_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic       busy;
    logic       done;
    logic       mem_read_en;
    logic [3:0] mem_read_address;
    logic [7:0] mem_data_out = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
`ifdef MEM3_READER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    logic [7:0] mem [16];
    logic [7:0] sb [$];
    logic [3:0] addr_log [$];
    int         checks = 0;
    int         errors = 0;
    int         issued = 0;
    int         popped = 0;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    mem3_reader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .mem_read_en      (mem_read_en),
        .mem_read_address (mem_read_address),
        .mem_data_out     (mem_data_out),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data)
`ifdef MEM3_READER_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    always #5 clk = ~clk;

    // mem3 model: registered read, data valid the cycle after read_en is sampled
    always @(posedge clk) begin
        if (mem_read_en) mem_data_out <= mem[mem_read_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_valid && !prev_hs) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (mem_read_en) begin
                issued++;
                addr_log.push_back(mem_read_address);
            end
            if (m_valid && m_ready) begin
                popped++;
                if (sb.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    check("m_data", m_data, sb.pop_front());
                end
            end
            check("outstanding_le2", (issued - popped <= 2), 1);
            prev_valid = m_valid;
            prev_hs    = m_valid & m_ready;
            prev_data  = m_data;
        end
    end

    function automatic logic rdy(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1: begin
                case ((k - 1) % 6)
                    0, 3, 5: return 1'b1;
                    default: return 1'b0;
                endcase
            end
            default: return (k >= 9);
        endcase
    endfunction

    task automatic run_burst(input logic [3:0] base, input logic [4:0] len,
                             input int mode, input bit mid_start);
        int         k;
        int         first_v;
        int         done_k;
        bit         seen;
        logic [7:0] exp_ck;
        exp_ck = 8'h00;
        addr_log.delete();
        issued = 0;
        popped = 0;
        for (int i = 0; i < int'(len); i++) begin
            sb.push_back(mem[(int'(base) + i) % 16]);
            exp_ck ^= mem[(int'(base) + i) % 16];
        end
        base_addr = base;
        length    = len;
        start     = 1'b1;
        m_ready   = rdy(mode, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("rd_en_after_start", mem_read_en, (len != 0));
        if (len != 0) check("first_addr", mem_read_address, base);
        k = 1; first_v = -1; done_k = -1; seen = 0;
        while (!seen && k < 400) begin
            m_ready = rdy(mode, k);
            if (mid_start && k == 2) begin
                start     = 1'b1;
                base_addr = base + 4'd5;
                length    = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (m_valid && first_v < 0) first_v = k;
            if (done) begin
                seen   = 1;
                done_k = k;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        if (mode == 0) check("done_cycle", done_k, (len == 0) ? 1 : int'(len) + 3);
        if (mode == 0) check("first_valid_cycle", first_v, (len == 0) ? -1 : 3);
        check("sb_empty", sb.size(), 0);
        check("reads_issued", issued, len);
        for (int i = 0; i < addr_log.size(); i++) begin
            check("rd_addr", addr_log[i], (int'(base) + i) % 16);
        end
`ifdef MEM3_READER_CHECKSUM_EN
        check("checksum", checksum, exp_ck);
`endif
    endtask

    initial begin
        int  k;
        bit  any_done;
        for (int i = 0; i < 16; i++) mem[i] = 8'((i + 1) * 8'h11);
        rst = 1'b1; start = 1'b0; base_addr = 4'd0; length = 5'd0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_read_en, 0);
        check("rst_addr", mem_read_address, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
`ifdef MEM3_READER_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run_burst(4'd0,  5'd4,  0, 0);   // 0x11,0x22,0x33,0x44
        run_burst(4'd14, 5'd4,  0, 0);   // address wrap 14,15,0,1
        run_burst(4'd3,  5'd4,  1, 0);   // toggling ready
        run_burst(4'd7,  5'd6,  2, 0);   // long stall then drain
        run_burst(4'd0,  5'd0,  0, 0);   // zero length
        run_burst(4'd9,  5'd4,  0, 1);   // start ignored mid-burst
        run_burst(4'd0,  5'd16, 0, 0);   // maximum length

        // Reset after two words of an eight-word burst
        issued = 0; popped = 0;
        for (int i = 0; i < 8; i++) sb.push_back(mem[(4 + i) % 16]);
        base_addr = 4'd4; length = 5'd8; start = 1'b1; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (popped < 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("two_words_before_rst", (popped >= 2), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_en", mem_read_en, 0);
        check("mid_rst_addr", mem_read_address, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        rst = 1'b0;
        any_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || m_valid) any_done = 1;
            @(posedge clk); #1;
        end
        check("no_activity_after_rst", any_done, 0);
        run_burst(4'd0, 5'd8, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
